// File: rtl/tlp_pkg.sv
// Shared TLP definitions: fmt_type codes, the request header layout and the completer FSM states.
package tlp_pkg;
   localparam logic [7:0] FT_MWR32    = 8'h40;
   localparam logic [7:0] FT_MRD32    = 8'h00;
   localparam logic [7:0] FT_CPLD     = 8'h4A;
   localparam logic [9:0] TLP_LEN_32B = 10'd8;

   // DW0 | DW1 | DW2, most significant field first.
   typedef struct packed {
      logic [7:0]  fmt_type;
      logic [13:0] rsvd;
      logic [9:0]  length;
      logic [15:0] req_id;
      logic [7:0]  tag;
      logic [7:0]  be;
      logic [31:0] addr;
   } tlp_hdr_t;

   typedef enum logic [3:0] {
      HDR0, HDR1, HDR2, PAYLOAD, CPL_H0, CPL_H1, CPL_H2, CPL_DATA, DROP
   } tlp_state_e;
endpackage

// File: rtl/tlp_line_ram.sv
// Single-port DEPTH x 256 line store, 1-cycle read latency, write-first.
// Read data holds its value until the next enabled access.
module tlp_line_ram #(
   parameter int DEPTH = 64,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          en,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [255:0]  wdata,
   output logic [255:0]  rdata
);
   logic [255:0] mem_q [DEPTH];
   logic [255:0] rdata_q;

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem_q[addr] <= wdata;
            rdata_q     <= wdata;
         end else begin
            rdata_q     <= mem_q[addr];
         end
      end
   end

   assign rdata = rdata_q;
endmodule

// File: rtl/tlp_completer.sv
// Link-side completer: executes 32-byte MWr/MRd TLPs against a local line RAM, pulses ack/nack,
// and returns CplD for reads; one request in flight, rx stalls during completion, tx honours ready.
module tlp_completer
   import tlp_pkg::*;
#(
   parameter int          DEPTH  = 64,
   parameter logic [15:0] CPL_ID = 16'h0100
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] rx_tlp_data,
   input  logic        rx_tlp_valid,
   output logic        rx_tlp_ready,
   output logic [31:0] tx_tlp_data,
   output logic        tx_tlp_valid,
   input  logic        tx_tlp_ready,
   output logic        ack,
   output logic        nack
);
   localparam int AW = $clog2(DEPTH);

   tlp_state_e    state_q, state_d;
   tlp_hdr_t      hdr_q, hdr_d;
   logic [255:0]  payload_q, payload_d;
   logic [9:0]    cnt_q, cnt_d;
   logic          ack_q, ack_d;
   logic          nack_q, nack_d;

   logic          rx_open, rx_acc, req_ok;
   logic          ram_rd, ram_we;
   logic [AW-1:0] ram_addr;
   logic [255:0]  ram_wdata, ram_rdata;
   logic [31:0]   addr_hi;
   logic          unused_bits;

   assign rx_open      = state_q inside {HDR0, HDR1, HDR2, PAYLOAD, DROP};
   assign rx_tlp_ready = rx_open && !rst;
   assign rx_acc       = rx_tlp_valid && rx_tlp_ready;

   // Validation happens while DW2 is on the bus, so the address comes straight from rx.
   assign addr_hi = rx_tlp_data >> (AW + 5);
   assign req_ok  = (hdr_q.fmt_type == FT_MWR32 || hdr_q.fmt_type == FT_MRD32) &&
                    hdr_q.length == TLP_LEN_32B && hdr_q.be == 8'hFF &&
                    rx_tlp_data[4:0] == 5'd0 && addr_hi == 32'd0;

   assign ram_addr  = (state_q == HDR2) ? rx_tlp_data[AW+4:5] : hdr_q.addr[AW+4:5];
   assign ram_wdata = {rx_tlp_data, payload_q[223:0]};

   always_comb begin
      state_d      = state_q;
      hdr_d        = hdr_q;
      payload_d    = payload_q;
      cnt_d        = cnt_q;
      ack_d        = 1'b0;
      nack_d       = 1'b0;
      ram_rd       = 1'b0;
      ram_we       = 1'b0;
      tx_tlp_valid = 1'b0;
      tx_tlp_data  = 32'd0;
      case (state_q)
         HDR0: if (rx_acc) begin
            {hdr_d.fmt_type, hdr_d.rsvd, hdr_d.length} = rx_tlp_data;
            state_d = HDR1;
         end
         HDR1: if (rx_acc) begin
            {hdr_d.req_id, hdr_d.tag, hdr_d.be} = rx_tlp_data;
            state_d = HDR2;
         end
         HDR2: if (rx_acc) begin
            hdr_d.addr = rx_tlp_data;
            if (req_ok && hdr_q.fmt_type == FT_MWR32) begin
               cnt_d   = 10'd0;
               state_d = PAYLOAD;
            end else if (req_ok) begin
               ram_rd  = 1'b1;
               ack_d   = 1'b1;
               state_d = CPL_H0;
            end else if (hdr_q.fmt_type[6] && hdr_q.length != 10'd0) begin
               cnt_d   = hdr_q.length;
               state_d = DROP;
            end else begin
               nack_d  = 1'b1;
               state_d = HDR0;
            end
         end
         PAYLOAD: if (rx_acc) begin
            payload_d[{cnt_q[2:0], 5'd0} +: 32] = rx_tlp_data;
            cnt_d = cnt_q + 10'd1;
            if (cnt_q[2:0] == 3'd7) begin
               ram_we  = 1'b1;
               ack_d   = 1'b1;
               state_d = HDR0;
            end
         end
         CPL_H0: begin
            tx_tlp_valid = 1'b1;
            tx_tlp_data  = {FT_CPLD, 14'd0, TLP_LEN_32B};
            if (tx_tlp_ready) state_d = CPL_H1;
         end
         CPL_H1: begin
            tx_tlp_valid = 1'b1;
            tx_tlp_data  = {CPL_ID, 3'b000, 1'b0, 12'd32};
            if (tx_tlp_ready) state_d = CPL_H2;
         end
         CPL_H2: begin
            tx_tlp_valid = 1'b1;
            tx_tlp_data  = {hdr_q.req_id, hdr_q.tag, 1'b0, hdr_q.addr[6:0]};
            if (tx_tlp_ready) begin
               cnt_d   = 10'd0;
               state_d = CPL_DATA;
            end
         end
         CPL_DATA: begin
            tx_tlp_valid = 1'b1;
            tx_tlp_data  = ram_rdata[{cnt_q[2:0], 5'd0} +: 32];
            if (tx_tlp_ready) begin
               cnt_d = cnt_q + 10'd1;
               if (cnt_q[2:0] == 3'd7) state_d = HDR0;
            end
         end
         DROP: if (rx_acc) begin
            cnt_d = cnt_q - 10'd1;
            if (cnt_q == 10'd1) begin
               nack_d  = 1'b1;
               state_d = HDR0;
            end
         end
         default: state_d = HDR0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= HDR0;
         cnt_q   <= 10'd0;
         ack_q   <= 1'b0;
         nack_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ack_q   <= ack_d;
         nack_q  <= nack_d;
      end
   end

   always_ff @(posedge clk) begin
      hdr_q     <= hdr_d;
      payload_q <= payload_d;
   end

   assign ack  = ack_q;
   assign nack = nack_q;

   tlp_line_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
      .clk   (clk),
      .en    (ram_rd || ram_we),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   assign unused_bits = ^{hdr_q.rsvd, hdr_q.addr, payload_q[255:224]};
endmodule

// File: tb/tb_tlp_completer.sv
// Directed bench for tlp_completer: table of TLPs with hand-computed ack/nack and completion data,
// plus a hand-written mid-payload reset sequence.
module tb_tlp_completer;
   import tlp_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] rx_tlp_data;
   logic        rx_tlp_valid;
   logic        rx_tlp_ready;
   logic [31:0] tx_tlp_data;
   logic        tx_tlp_valid;
   logic        tx_tlp_ready;
   logic        ack;
   logic        nack;

   always #5 clk = ~clk;

   tlp_completer #(.DEPTH(64), .CPL_ID(16'h0100)) dut (
      .clk          (clk),
      .rst          (rst),
      .rx_tlp_data  (rx_tlp_data),
      .rx_tlp_valid (rx_tlp_valid),
      .rx_tlp_ready (rx_tlp_ready),
      .tx_tlp_data  (tx_tlp_data),
      .tx_tlp_valid (tx_tlp_valid),
      .tx_tlp_ready (tx_tlp_ready),
      .ack          (ack),
      .nack         (nack)
   );

   typedef struct {
      logic [7:0]  fmt;
      logic [9:0]  len;
      logic [7:0]  be;
      logic [31:0] addr;
      logic [15:0] rid;
      logic [7:0]  tag;
      int          npay;
      logic [31:0] base;
      logic [31:0] step;
      bit          tog;
      bit          exp_ack;
      bit          exp_nack;
   } vec_t;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          ack_cnt = 0;
   int          nack_cnt = 0;
   int          waits;
   logic [31:0] model_mem [64][8];
   vec_t        vecs [16];

   always @(negedge clk) begin
      if (!rst && ack)  ack_cnt  <= ack_cnt + 1;
      if (!rst && nack) nack_cnt <= nack_cnt + 1;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1, "watchdog");
   end

   function automatic vec_t mk(input logic [7:0] fmt, input logic [9:0] len, input logic [7:0] be,
                               input logic [31:0] addr, input logic [15:0] rid, input logic [7:0] tag,
                               input int npay, input logic [31:0] base, input logic [31:0] step,
                               input bit tog, input bit ea, input bit en);
      vec_t v;
      v.fmt = fmt; v.len = len; v.be = be; v.addr = addr; v.rid = rid; v.tag = tag;
      v.npay = npay; v.base = base; v.step = step; v.tog = tog; v.exp_ack = ea; v.exp_nack = en;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h, want %08h", nm, act, exp);
      end
   endtask

   task automatic send_beat(input logic [31:0] d);
      int n = 0;
      rx_tlp_data  = d;
      rx_tlp_valid = 1'b1;
      while (!rx_tlp_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      waits += n;
      if (n >= 100) begin
         n_tests++;
         n_fail++;
         $display("FAIL rx_ready_timeout: ready low for %0d cycles, want 1", n);
      end
      @(posedge clk); #1;
      rx_tlp_valid = 1'b0;
   endtask

   task automatic apply(input vec_t v, input int idx);
      int          a0, n0, line, got, cyc, stall_err, rdy_err;
      logic [31:0] exp_dw [11];
      logic [31:0] got_dw [11];
      logic [31:0] prev;
      bit          stalled, is_rd;
      a0 = ack_cnt; n0 = nack_cnt; waits = 0;
      line  = int'(v.addr[10:5]);
      is_rd = (v.fmt == 8'h00) && v.exp_ack;
      send_beat({v.fmt, 14'd0, v.len});
      send_beat({v.rid, v.tag, v.be});
      send_beat(v.addr);
      for (int k = 0; k < v.npay; k++) send_beat(v.base + 32'(k) * v.step);
      chk($sformatf("v%0d ack_timing", idx), {31'd0, ack}, {31'd0, v.exp_ack});
      chk($sformatf("v%0d nack_timing", idx), {31'd0, nack}, {31'd0, v.exp_nack});
      if (is_rd) begin
         chk($sformatf("v%0d tx_valid_first", idx), {31'd0, tx_tlp_valid}, 32'd1);
         exp_dw[0] = 32'h4A000008;
         exp_dw[1] = 32'h01000020;
         exp_dw[2] = {v.rid, v.tag, 1'b0, v.addr[6:0]};
         for (int k = 0; k < 8; k++) exp_dw[3+k] = model_mem[line][k];
         got = 0; cyc = 0; stall_err = 0; rdy_err = 0; stalled = 1'b0; prev = 32'd0;
         while (got < 11 && cyc < 300) begin
            tx_tlp_ready = v.tog ? cyc[0] : 1'b1;
            if (stalled && tx_tlp_data !== prev) stall_err++;
            if (tx_tlp_valid && rx_tlp_ready) rdy_err++;
            if (tx_tlp_valid) begin
               if (tx_tlp_ready) begin
                  got_dw[got] = tx_tlp_data;
                  got++;
                  stalled = 1'b0;
               end else begin
                  stalled = 1'b1;
                  prev    = tx_tlp_data;
               end
            end
            @(posedge clk); #1;
            cyc++;
         end
         tx_tlp_ready = 1'b0;
         if (got < 11) begin
            n_tests++;
            n_fail++;
            $display("FAIL v%0d cpl_timeout: got %0d dwords, want 11", idx, got);
         end else begin
            for (int k = 0; k < 11; k++)
               chk($sformatf("v%0d cpl_dw%0d", idx, k), got_dw[k], exp_dw[k]);
            chk($sformatf("v%0d rx_ready_after_cpl", idx), {31'd0, rx_tlp_ready}, 32'd1);
         end
         chk($sformatf("v%0d stall_stable", idx), stall_err, 32'd0);
         chk($sformatf("v%0d rx_ready_in_cpl", idx), rdy_err, 32'd0);
      end else begin
         chk($sformatf("v%0d no_tx_valid", idx), {31'd0, tx_tlp_valid}, 32'd0);
         chk($sformatf("v%0d rx_ready_next", idx), {31'd0, rx_tlp_ready}, 32'd1);
      end
      @(posedge clk); #1;
      chk($sformatf("v%0d ack_count", idx), ack_cnt - a0, {31'd0, v.exp_ack});
      chk($sformatf("v%0d nack_count", idx), nack_cnt - n0, {31'd0, v.exp_nack});
      chk($sformatf("v%0d rx_stall_cycles", idx), waits, 32'd0);
      if (v.fmt == 8'h40 && v.exp_ack)
         for (int k = 0; k < 8; k++) model_mem[line][k] = v.base + 32'(k) * v.step;
   endtask

   initial begin
      int a0;
      //                fmt    len    be     addr          rid       tag    np base          step      tog ack nack
      vecs[0]  = mk(8'h40, 10'd8, 8'hFF, 32'h0000_0000, 16'h0000, 8'h00, 8, 32'h0123_4567, 32'd0,     0, 1, 0);
      vecs[1]  = mk(8'h00, 10'd8, 8'hFF, 32'h0000_0000, 16'h0001, 8'h05, 0, 32'd0,         32'd0,     0, 1, 0);
      vecs[2]  = mk(8'h40, 10'd8, 8'hFF, 32'h0000_0020, 16'h0000, 8'h00, 8, 32'd0,         32'd1,     0, 1, 0);
      vecs[3]  = mk(8'h00, 10'd8, 8'hFF, 32'h0000_0020, 16'h0002, 8'h11, 0, 32'd0,         32'd0,     1, 1, 0);
      vecs[4]  = mk(8'h00, 10'd8, 8'hFF, 32'h0000_0010, 16'h0001, 8'h06, 0, 32'd0,         32'd0,     0, 0, 1);
      vecs[5]  = mk(8'h44, 10'd3, 8'hFF, 32'h0000_0020, 16'h0001, 8'h07, 3, 32'hBAD0_0000, 32'd1,     0, 0, 1);
      vecs[6]  = mk(8'h00, 10'd8, 8'hFF, 32'h0000_0020, 16'h0001, 8'h08, 0, 32'd0,         32'd0,     0, 1, 0);
      vecs[7]  = mk(8'h00, 10'd8, 8'hFF, 32'h0000_0800, 16'h0001, 8'h09, 0, 32'd0,         32'd0,     0, 0, 1);
      vecs[8]  = mk(8'h40, 10'd4, 8'hFF, 32'h0000_0000, 16'h0001, 8'h0A, 4, 32'hAAAA_0000, 32'd1,     0, 0, 1);
      vecs[9]  = mk(8'h00, 10'd8, 8'hFF, 32'h0000_0000, 16'h0001, 8'h0B, 0, 32'd0,         32'd0,     0, 1, 0);
      vecs[10] = mk(8'h00, 10'd8, 8'h0F, 32'h0000_0000, 16'h0001, 8'h0C, 0, 32'd0,         32'd0,     0, 0, 1);
      vecs[11] = mk(8'h00, 10'd4, 8'hFF, 32'h0000_0000, 16'h0001, 8'h0D, 0, 32'd0,         32'd0,     0, 0, 1);
      vecs[12] = mk(8'h40, 10'd8, 8'hFF, 32'h0000_07E0, 16'h0000, 8'h00, 8, 32'hDEAD_0000, 32'h111,   0, 1, 0);
      vecs[13] = mk(8'h00, 10'd8, 8'hFF, 32'h0000_07E0, 16'hABCD, 8'hFF, 0, 32'd0,         32'd0,     0, 1, 0);
      vecs[14] = mk(8'h40, 10'd8, 8'hFF, 32'h0000_0040, 16'h0000, 8'h00, 8, 32'hC0DE_0000, 32'd1,     0, 1, 0);
      vecs[15] = mk(8'h00, 10'd8, 8'hFF, 32'h0000_0040, 16'h0003, 8'h22, 0, 32'd0,         32'd0,     1, 1, 0);

      rst = 1'b1; rx_tlp_valid = 1'b0; rx_tlp_data = 32'd0; tx_tlp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset rx_ready", {31'd0, rx_tlp_ready}, 32'd0);
      chk("reset tx_valid", {31'd0, tx_tlp_valid}, 32'd0);
      chk("reset tx_data", tx_tlp_data, 32'd0);
      chk("reset ack", {31'd0, ack}, 32'd0);
      chk("reset nack", {31'd0, nack}, 32'd0);
      rst = 1'b0;
      #1;
      chk("rx_ready after reset", {31'd0, rx_tlp_ready}, 32'd1);

      for (int i = 0; i < 15; i++) apply(vecs[i], i);

      // Reset lands on payload beat 5 of an MWr to line 2; the old line contents must survive.
      a0 = ack_cnt;
      send_beat({8'h40, 14'd0, 10'd8});
      send_beat({16'h0000, 8'h00, 8'hFF});
      send_beat(32'h0000_0040);
      for (int k = 0; k < 4; k++) send_beat(32'h5555_0000 + 32'(k));
      rx_tlp_data  = 32'h5555_0004;
      rx_tlp_valid = 1'b1;
      rst          = 1'b1;
      @(posedge clk); #1;
      rx_tlp_valid = 1'b0;
      chk("midrst rx_ready", {31'd0, rx_tlp_ready}, 32'd0);
      chk("midrst tx_valid", {31'd0, tx_tlp_valid}, 32'd0);
      chk("midrst tx_data", tx_tlp_data, 32'd0);
      chk("midrst ack", {31'd0, ack}, 32'd0);
      chk("midrst nack", {31'd0, nack}, 32'd0);
      rst = 1'b0;
      #1;
      chk("midrst rx_ready_release", {31'd0, rx_tlp_ready}, 32'd1);
      @(posedge clk); #1;
      chk("midrst ack_count", ack_cnt - a0, 32'd0);
      apply(vecs[15], 15);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
